// File: rtl/snn_pkg.sv
// Shared definitions for the SNN host interface.
// Holds the controller state encoding, the ASCII codes used for the
// result line, and the digit-to-character mapping.
package snn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_UNPACK,
        S_START,
        S_WAIT_CORE,
        S_TX_CHAR,
        S_TX_CR,
        S_TX_LF
    } state_e;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Decimal digits map to '0'..'9'; anything the core reports above 9
    // is not a valid class and is shown as '?'.
    function automatic logic [7:0] digit_char(input logic [7:0] digit);
        return (digit <= 8'd9) ? (ASCII_0 + digit) : ASCII_Q;
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Serialises one received byte, LSB first.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load_i      capture data_i and restart the bit count
//   data_i      byte to serialise
//   shift_i     advance to the next bit
//   bit_o       current bit (LSB of the shift register)
//   done_o      high while the eighth bit is presented
module byte_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       shift_i,
    output logic       bit_o,
    output logic       done_o
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = 3'd0;
        end else if (shift_i) begin
            sr_d  = {1'b0, sr_q[7:1]};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= 8'h00;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o  = sr_q[0];
    assign done_o = (cnt_q == 3'd7);

endmodule

// File: rtl/snn_host_if.sv
// Host-side controller for the SNN digit classifier.
// Receives a packed 1-bit-per-pixel image over a byte stream, unpacks it
// into the bit-addressed input memory, starts the core, and sends the
// result back as an ASCII character (optionally followed by CR LF).
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   rx_rdy, rx_data        received byte strobe and data
//   mem_we/addr/wdata      input-memory bit write
//   core_start             one-cycle start pulse to the core
//   core_done, core_digit  core result strobe and value
//   tx_start, tx_data      transmit request and byte (held until next request)
//   tx_rdy                 transmitter idle
//   led                    last result, zero-extended
//   busy                   high outside IDLE and WAIT_BYTE
//   frame_err              sticky timeout/overrun flag
module snn_host_if
    import snn_pkg::*;
#(
    parameter int IMG_BITS    = 784,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int CRLF_EN     = 1,
    parameter int DIGIT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_rdy,
    input  logic [7:0]                  rx_data,
    output logic                        mem_we,
    output logic [$clog2(IMG_BITS)-1:0] mem_addr,
    output logic                        mem_wdata,
    output logic                        core_start,
    input  logic                        core_done,
    input  logic [DIGIT_W-1:0]          core_digit,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    input  logic                        tx_rdy,
    output logic [7:0]                  led,
    output logic                        busy,
    output logic                        frame_err
);

    localparam int AW = $clog2(IMG_BITS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW-1:0] LAST_BIT = AW'(IMG_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    led_q, led_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          frame_err_q, frame_err_d;

    logic unp_load, unp_shift, unp_bit, unp_done;

    byte_unpacker u_unpacker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (unp_load),
        .data_i  (rx_data),
        .shift_i (unp_shift),
        .bit_o   (unp_bit),
        .done_o  (unp_done)
    );

    assign busy = !((state_q == S_IDLE) || (state_q == S_WAIT_BYTE));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = '0;          // held at zero outside WAIT_BYTE
        led_d       = led_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = frame_err_q;
        unp_load    = 1'b0;
        unp_shift   = 1'b0;
        mem_we      = 1'b0;
        core_start  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_rdy) begin
                    unp_load    = 1'b1;
                    frame_err_d = 1'b0;  // first byte of a new frame
                    state_d     = S_UNPACK;
                end
            end
            S_WAIT_BYTE: begin
                // Expiry is checked before rx_rdy so a byte arriving on the
                // expiry cycle is dropped.
                if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = S_IDLE;
                end else if (rx_rdy) begin
                    unp_load = 1'b1;
                    state_d  = S_UNPACK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_UNPACK: begin
                mem_we    = 1'b1;
                unp_shift = 1'b1;
                // Stopping at the last image bit leaves the padding bits of
                // the final byte unwritten.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_START;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (unp_done) state_d = S_WAIT_BYTE;
                end
            end
            S_START: begin
                core_start = 1'b1;
                bit_cnt_d  = '0;
                state_d    = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    led_d   = 8'(core_digit);
                    state_d = S_TX_CHAR;
                end
            end
            // tx_rdy is ignored while the previous request is still on the
            // wire, since the transmitter has not yet had a chance to drop it.
            S_TX_CHAR: begin
                if (tx_rdy && !tx_start_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = digit_char(led_q);
                    state_d    = (CRLF_EN != 0) ? S_TX_CR : S_IDLE;
                end
            end
            S_TX_CR: begin
                if (tx_rdy && !tx_start_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ASCII_CR;
                    state_d    = S_TX_LF;
                end
            end
            S_TX_LF: begin
                if (tx_rdy && !tx_start_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ASCII_LF;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Overrun: the byte was never loaded above, only flag it.
        if (busy && rx_rdy) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            led_q       <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
            led_q       <= led_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem_addr  = bit_cnt_q;
    assign mem_wdata = unp_bit;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign led       = led_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_snn_host_if.sv
// Bench for snn_host_if: two instances share one stimulus stream.
//   A: IMG_BITS=16, CRLF_EN=1, TIMEOUT_CYC=100
//   B: IMG_BITS=12, CRLF_EN=0, TIMEOUT_CYC=100
// Both images need two bytes, so one frame drives both designs.
module tb_snn_host_if;

    localparam int A_BITS = 16;
    localparam int B_BITS = 12;
    localparam int TMO    = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'h0;
    logic       tx_rdy = 1'b1;

    logic       a_mem_we, a_mem_wdata, a_core_start, a_tx_start, a_busy, a_frame_err;
    logic [3:0] a_mem_addr;
    logic [7:0] a_tx_data, a_led;
    logic       b_mem_we, b_mem_wdata, b_core_start, b_tx_start, b_busy, b_frame_err;
    logic [3:0] b_mem_addr;
    logic [7:0] b_tx_data, b_led;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_led = 8'h00;

    // Monitor records
    int         a_wr[$], b_wr[$];       // addr*2 + bit
    logic [7:0] a_tx[$], b_tx[$];
    int         a_txc[$], b_txc[$];
    int         a_starts = 0, b_starts = 0;
    int         a_tx_long = 0, b_tx_long = 0;
    logic       a_tx_prev = 1'b0, b_tx_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    snn_host_if #(.IMG_BITS(A_BITS), .TIMEOUT_CYC(TMO), .CRLF_EN(1), .DIGIT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .core_start(a_core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_start(a_tx_start), .tx_data(a_tx_data), .tx_rdy(tx_rdy),
        .led(a_led), .busy(a_busy), .frame_err(a_frame_err)
    );

    snn_host_if #(.IMG_BITS(B_BITS), .TIMEOUT_CYC(TMO), .CRLF_EN(0), .DIGIT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .core_start(b_core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_rdy(tx_rdy),
        .led(b_led), .busy(b_busy), .frame_err(b_frame_err)
    );

    always @(negedge clk) begin
        if (a_mem_we) a_wr.push_back(int'(a_mem_addr) * 2 + int'(a_mem_wdata));
        if (b_mem_we) b_wr.push_back(int'(b_mem_addr) * 2 + int'(b_mem_wdata));
        if (a_core_start) a_starts++;
        if (b_core_start) b_starts++;
        if (a_tx_start) begin
            a_tx.push_back(a_tx_data);
            a_txc.push_back(cyc);
            if (a_tx_prev) a_tx_long++;
        end
        if (b_tx_start) begin
            b_tx.push_back(b_tx_data);
            b_txc.push_back(cyc);
            if (b_tx_prev) b_tx_long++;
        end
        a_tx_prev = a_tx_start;
        b_tx_prev = b_tx_start;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic pulse_rx(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic pulse_core(input logic [3:0] d);
        @(negedge clk);
        core_done  = 1'b1;
        core_digit = d;
        @(negedge clk);
        core_done  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({a_mem_we, a_core_start, a_tx_start, a_busy, a_frame_err, a_mem_addr} !== 9'd0) begin
            errors++;
            $display("FAIL reset_a_ctrl: got %b, want 0", {a_mem_we, a_core_start, a_tx_start, a_busy, a_frame_err, a_mem_addr});
        end
        checks++;
        if ({a_led, a_tx_data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_a_data: led/tx_data got %h, want 0000", {a_led, a_tx_data});
        end
        checks++;
        if ({b_mem_we, b_core_start, b_tx_start, b_busy, b_frame_err, b_led, b_tx_data} !== 21'd0) begin
            errors++;
            $display("FAIL reset_b: got %h, want 0", {b_mem_we, b_core_start, b_tx_start, b_busy, b_frame_err, b_led, b_tx_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Sends a two-byte frame, returns a digit, and checks memory writes,
    // the start pulse, LED and transmitted bytes against the image rules.
    task automatic test_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [3:0] d, input bit overrun, input string tag);
        int wa, wb, sa, sb, ta, tb, la, lb, e, g;
        logic [7:0] img [2];
        logic [7:0] ch;
        logic [7:0] a_exp [3];
        wa = a_wr.size(); wb = b_wr.size();
        sa = a_starts;    sb = b_starts;
        ta = a_tx.size(); tb = b_tx.size();
        la = a_tx_long;   lb = b_tx_long;
        img[0] = b0; img[1] = b1;
        ch = (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
        a_exp[0] = ch; a_exp[1] = 8'h0D; a_exp[2] = 8'h0A;

        pulse_rx(b0);
        repeat (10) @(negedge clk);
        checks++;
        if ({a_frame_err, b_frame_err, a_busy, b_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_first_byte: err_a/err_b/busy_a/busy_b got %b, want 0000", tag, {a_frame_err, b_frame_err, a_busy, b_busy});
        end
        pulse_rx(b1);
        repeat (10) @(negedge clk);

        checks++;
        if (a_wr.size() - wa !== A_BITS) begin
            errors++;
            $display("FAIL %s_a_wcount: got %0d, want %0d", tag, a_wr.size() - wa, A_BITS);
        end
        for (int i = 0; i < A_BITS; i++) begin
            if (a_wr.size() > wa + i) begin
                e = i * 2 + int'(img[i / 8][i % 8]);
                checks++;
                if (a_wr[wa + i] !== e) begin
                    errors++;
                    $display("FAIL %s_a_bit%0d: addr/bit got %0d/%0d, want %0d/%0d", tag, i, a_wr[wa + i] / 2, a_wr[wa + i] % 2, e / 2, e % 2);
                end
            end
        end
        checks++;
        if (b_wr.size() - wb !== B_BITS) begin
            errors++;
            $display("FAIL %s_b_wcount: got %0d, want %0d", tag, b_wr.size() - wb, B_BITS);
        end
        for (int i = 0; i < B_BITS; i++) begin
            if (b_wr.size() > wb + i) begin
                e = i * 2 + int'(img[i / 8][i % 8]);
                checks++;
                if (b_wr[wb + i] !== e) begin
                    errors++;
                    $display("FAIL %s_b_bit%0d: addr/bit got %0d/%0d, want %0d/%0d", tag, i, b_wr[wb + i] / 2, b_wr[wb + i] % 2, e / 2, e % 2);
                end
            end
        end
        checks++;
        if ({a_starts - sa, b_starts - sb} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL %s_starts: a/b got %0d/%0d, want 1/1", tag, a_starts - sa, b_starts - sb);
        end
        checks++;
        if ({a_busy, b_busy} !== 2'b11) begin
            errors++;
            $display("FAIL %s_busy_wait: got %b, want 11", tag, {a_busy, b_busy});
        end

        if (overrun) begin
            pulse_rx(8'($urandom));
            repeat (2) @(negedge clk);
            checks++;
            if ({a_frame_err, b_frame_err, a_busy, b_busy} !== 4'b1111) begin
                errors++;
                $display("FAIL %s_overrun_flag: err_a/err_b/busy_a/busy_b got %b, want 1111", tag, {a_frame_err, b_frame_err, a_busy, b_busy});
            end
            checks++;
            if ((a_wr.size() - wa !== A_BITS) || (b_wr.size() - wb !== B_BITS)) begin
                errors++;
                $display("FAIL %s_overrun_write: a/b writes got %0d/%0d, want %0d/%0d", tag, a_wr.size() - wa, b_wr.size() - wb, A_BITS, B_BITS);
            end
        end

        pulse_core(d);
        repeat (20) @(negedge clk);
        exp_led = {4'h0, d};
        checks++;
        if ({a_led, b_led} !== {exp_led, exp_led}) begin
            errors++;
            $display("FAIL %s_led: a/b got %h/%h, want %h", tag, a_led, b_led, exp_led);
        end
        checks++;
        if (a_tx.size() - ta !== 3) begin
            errors++;
            $display("FAIL %s_a_txcount: got %0d, want 3", tag, a_tx.size() - ta);
        end
        for (int k = 0; k < 3; k++) begin
            if (a_tx.size() > ta + k) begin
                checks++;
                if (a_tx[ta + k] !== a_exp[k]) begin
                    errors++;
                    $display("FAIL %s_a_tx%0d: got %h, want %h", tag, k, a_tx[ta + k], a_exp[k]);
                end
                if (k > 0) begin
                    g = a_txc[ta + k] - a_txc[ta + k - 1];
                    checks++;
                    if (g < 2) begin
                        errors++;
                        $display("FAIL %s_a_txgap%0d: got %0d cycles, want >= 2", tag, k, g);
                    end
                end
            end
        end
        checks++;
        if (b_tx.size() - tb !== 1) begin
            errors++;
            $display("FAIL %s_b_txcount: got %0d, want 1", tag, b_tx.size() - tb);
        end else begin
            checks++;
            if (b_tx[tb] !== ch) begin
                errors++;
                $display("FAIL %s_b_tx: got %h, want %h", tag, b_tx[tb], ch);
            end
        end
        checks++;
        if ({a_tx_long - la, b_tx_long - lb} !== 64'd0) begin
            errors++;
            $display("FAIL %s_tx_pulse_len: a/b multi-cycle got %0d/%0d, want 0/0", tag, a_tx_long - la, b_tx_long - lb);
        end
        checks++;
        if ({a_busy, b_busy, a_frame_err, b_frame_err} !== {2'b00, overrun, overrun}) begin
            errors++;
            $display("FAIL %s_end_state: busy_a/busy_b/err_a/err_b got %b, want %b", tag, {a_busy, b_busy, a_frame_err, b_frame_err}, {2'b00, overrun, overrun});
        end
    endtask

    task automatic test_known_frame();
        test_frame(8'hA5, 8'h3C, 4'd7, 1'b0, "known");
    endtask

    task automatic test_partial_byte();
        test_frame(8'hFF, 8'hFF, 4'd12, 1'b0, "partial");
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++)
            test_frame(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, "random");
    endtask

    task automatic test_core_done_ignored();
        int ta, tb;
        ta = a_tx.size(); tb = b_tx.size();
        pulse_core(~exp_led[3:0]);
        repeat (10) @(negedge clk);
        checks++;
        if ({a_led, b_led} !== {exp_led, exp_led}) begin
            errors++;
            $display("FAIL idle_core_done_led: a/b got %h/%h, want %h", a_led, b_led, exp_led);
        end
        checks++;
        if ((a_tx.size() != ta) || (b_tx.size() != tb) || a_busy || b_busy) begin
            errors++;
            $display("FAIL idle_core_done_tx: new tx a/b got %0d/%0d busy %b%b, want 0/0 busy 00", a_tx.size() - ta, b_tx.size() - tb, a_busy, b_busy);
        end
    endtask

    task automatic test_overrun();
        test_frame(8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)), 1'b1, "overrun");
        test_frame(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, "after_overrun");
    endtask

    // One byte then silence. After the accept, 8 cycles of unpacking are
    // followed by TMO idle cycles; the flag is visible from the cycle after
    // the last idle one: 108 negedges after the rx pulse is cleared.
    task automatic test_timeout(input bit race);
        int wa, wb;
        wa = a_wr.size(); wb = b_wr.size();
        pulse_rx(8'($urandom));
        repeat (107) @(negedge clk);
        checks++;
        if ({a_frame_err, b_frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early: got %b, want 00", {a_frame_err, b_frame_err});
        end
        if (race) begin
            rx_rdy  = 1'b1;
            rx_data = 8'hFF;
        end
        @(negedge clk);
        rx_rdy = 1'b0;
        checks++;
        if ({a_frame_err, b_frame_err, a_busy, b_busy} !== 4'b1100) begin
            errors++;
            $display("FAIL timeout_flag(race=%0d): err_a/err_b/busy_a/busy_b got %b, want 1100", race, {a_frame_err, b_frame_err, a_busy, b_busy});
        end
        repeat (12) @(negedge clk);
        checks++;
        if ((a_wr.size() - wa != 8) || (b_wr.size() - wb != 8) || a_busy || b_busy) begin
            errors++;
            $display("FAIL timeout_drop(race=%0d): writes a/b got %0d/%0d, want 8/8", race, a_wr.size() - wa, b_wr.size() - wb);
        end
        test_frame(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, "after_timeout");
    endtask

    task automatic test_reset_mid();
        int wa, sa, sb, ta, tb;
        pulse_rx(8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_mem_we, a_core_start, a_tx_start, a_busy, a_frame_err, a_mem_addr, a_led, a_tx_data} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_a: got %h, want 0", {a_mem_we, a_core_start, a_tx_start, a_busy, a_frame_err, a_mem_addr, a_led, a_tx_data});
        end
        checks++;
        if ({b_mem_we, b_core_start, b_tx_start, b_busy, b_frame_err, b_mem_addr, b_led, b_tx_data} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_b: got %h, want 0", {b_mem_we, b_core_start, b_tx_start, b_busy, b_frame_err, b_mem_addr, b_led, b_tx_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_led = 8'h00;
        wa = a_wr.size(); sa = a_starts; sb = b_starts; ta = a_tx.size(); tb = b_tx.size();
        repeat (40) @(negedge clk);
        checks++;
        if ((a_starts != sa) || (b_starts != sb) || (a_tx.size() != ta) || (b_tx.size() != tb) || (a_wr.size() != wa)) begin
            errors++;
            $display("FAIL reset_mid_quiet: starts a/b %0d/%0d tx a/b %0d/%0d writes %0d, want all 0", a_starts - sa, b_starts - sb, a_tx.size() - ta, b_tx.size() - tb, a_wr.size() - wa);
        end
        test_frame(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_partial_byte();
        test_random();
        test_core_done_ignored();
        test_overrun();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
